// File: rtl/serial_out_pkg.sv
// Shared types and line-level constants for the serial output buffer.
package serial_out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_out_buffer_if.sv
// Grant/data handshake from the arbiter plus the serial line and FIFO status back.
interface serial_out_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data;
  logic              gnt_0;
  logic              gnt_1;
  logic              serial_out;
  logic              busy;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output data, gnt_0, gnt_1,
    input  serial_out, busy, full, empty, count, overflow
  );

  modport slave (
    input  data, gnt_0, gnt_1,
    output serial_out, busy, full, empty, count, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO; a push into a full FIFO is taken only when a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/serial_out_buffer.sv
// Buffers granted words and sends each as a start/8-data/stop frame, LSB first.
module serial_out_buffer
  import serial_out_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  serial_out_buffer_if.slave bus
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              serial_q;
  logic              overflow_q;

  logic              wr;
  logic              pop;
  logic              tick_last;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] head;

  assign wr        = bus.gnt_0 | bus.gnt_1;
  assign tick_last = (tick_cnt == TICK_LAST);
  // Pop only from registered occupancy, so a word written this edge waits one cycle.
  assign pop       = ~fifo_empty & ((state == IDLE) | ((state == STOP) & tick_last));

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr),
    .pop   (pop),
    .din   (bus.data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (pop)                          shift <= head;
    else if (state == DATA && tick_last) shift <= shift >> 1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      serial_q   <= LINE_IDLE;
      overflow_q <= 1'b0;
    end else begin
      if (wr && fifo_full && !pop) overflow_q <= 1'b1;
      case (state)
        IDLE: begin
          serial_q <= LINE_IDLE;
          if (pop) begin
            state    <= START;
            serial_q <= START_BIT;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (tick_last) begin
            tick_cnt <= '0;
            state    <= DATA;
            serial_q <= shift[0];
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick_last) begin
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              state    <= STOP;
              serial_q <= LINE_IDLE;
            end else begin
              serial_q <= shift[1];
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        STOP: begin
          if (tick_last) begin
            tick_cnt <= '0;
            // Chain straight into the next frame when a word is waiting.
            if (pop) begin
              state    <= START;
              serial_q <= START_BIT;
              bit_cnt  <= '0;
            end else begin
              state    <= IDLE;
              serial_q <= LINE_IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          serial_q <= LINE_IDLE;
        end
      endcase
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.busy       = (state != IDLE);
  assign bus.full       = fifo_full;
  assign bus.empty      = fifo_empty;
  assign bus.count      = fifo_count;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_out_buffer.sv
// Directed bench: expected words are queued at write time, a line receiver pops and compares each frame.
module tb_serial_out_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CPB    = 4;
  localparam int FRAME  = (DATA_W + 2) * CPB;

  logic clock;
  logic reset;

  serial_out_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  serial_out_buffer #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line receiver: every sample of a bit must agree; the frame is judged at its last sample.
  bit                rx_on = 1'b0;
  int                rx_samp;
  bit                rx_glitch;
  logic [DATA_W+1:0] rx_bits;
  logic [DATA_W-1:0] rx_exp;

  always @(negedge clock) begin
    if (reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (bus.serial_out === 1'b0) begin
        rx_on     = 1'b1;
        rx_samp   = 1;
        rx_glitch = 1'b0;
        rx_bits   = '0;
      end
    end else begin : rx_body
      int b;
      b = rx_samp / CPB;
      if (rx_samp % CPB == 0) rx_bits[b] = bus.serial_out;
      else if (rx_bits[b] !== bus.serial_out) rx_glitch = 1'b1;
      rx_samp++;
      if (rx_samp == FRAME) begin
        rx_on = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected got %0h expected none", rx_bits[DATA_W:1]);
        end else begin
          rx_exp = exp_q.pop_front();
          if (rx_glitch || rx_bits[0] !== 1'b0 || rx_bits[DATA_W+1] !== 1'b1 ||
              rx_bits[DATA_W:1] !== rx_exp) begin
            errors++;
            $display("FAIL frame_data got %0h (start %0b stop %0b glitch %0b) expected %0h",
                     rx_bits[DATA_W:1], rx_bits[0], rx_bits[DATA_W+1], rx_glitch, rx_exp);
          end
        end
      end
    end
  end

  task automatic wr(input logic [DATA_W-1:0] d, input logic g0, input logic g1, input bit accept);
    bus.data  = d;
    bus.gnt_0 = g0;
    bus.gnt_1 = g1;
    if (accept) exp_q.push_back(d);
    @(negedge clock);
    bus.gnt_0 = 1'b0;
    bus.gnt_1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (bus.busy && n < 1000) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((bus.busy || !bus.empty) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drain_done"}, 32'(n < 2000), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  int blen;

  initial begin
    reset     = 1'b1;
    bus.data  = '0;
    bus.gnt_0 = 1'b0;
    bus.gnt_1 = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_line_in_reset", bus.serial_out, 1);
    do_reset();
    check("rst_line", bus.serial_out, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_count", bus.count, 0);
    check("rst_overflow", bus.overflow, 0);

    // Single frame of 8'hA5
    wr(8'hA5, 1'b1, 1'b0, 1'b1);
    check("t1_count_e0", bus.count, 1);
    check("t1_line_e0", bus.serial_out, 1);
    check("t1_busy_e0", bus.busy, 0);
    @(negedge clock);
    check("t1_line_e1", bus.serial_out, 0);
    check("t1_busy_e1", bus.busy, 1);
    check("t1_count_e1", bus.count, 0);
    measure_busy(blen);
    check("t1_busy_len", blen, 40);
    check("t1_empty_after", bus.empty, 1);
    drain("t1");

    // Four back-to-back words, contiguous frames
    wr(8'h01, 1'b1, 1'b0, 1'b1);
    wr(8'h02, 1'b0, 1'b1, 1'b1);
    wr(8'h03, 1'b1, 1'b0, 1'b1);
    wr(8'h04, 1'b0, 1'b1, 1'b1);
    check("t2_count_peak", bus.count, 3);
    measure_busy(blen);
    check("t2_busy_len", blen + 2, 160);
    drain("t2");
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_overflow", bus.overflow, 0);

    // Fill during START, sixth word dropped
    wr(8'h11, 1'b1, 1'b0, 1'b1);
    wr(8'h22, 1'b1, 1'b0, 1'b1);
    wr(8'h33, 1'b1, 1'b0, 1'b1);
    wr(8'h44, 1'b1, 1'b0, 1'b1);
    wr(8'h55, 1'b1, 1'b0, 1'b1);
    check("t3_count_full", bus.count, 4);
    check("t3_full", bus.full, 1);
    check("t3_overflow_before", bus.overflow, 0);
    wr(8'h66, 1'b0, 1'b1, 1'b0);
    check("t3_overflow_set", bus.overflow, 1);
    check("t3_count_kept", bus.count, 4);
    drain("t3");
    check("t3_overflow_sticky", bus.overflow, 1);
    check("t3_queue_empty", exp_q.size(), 0);

    // Both grants together make a single entry
    wr(8'h3C, 1'b1, 1'b1, 1'b1);
    check("t4_count_one", bus.count, 1);
    drain("t4");
    check("t4_queue_empty", exp_q.size(), 0);

    // Write into a full FIFO on the STOP-end pop edge
    do_reset();
    check("t5_overflow_cleared", bus.overflow, 0);
    wr(8'hA1, 1'b1, 1'b0, 1'b1);
    wr(8'hA2, 1'b1, 1'b0, 1'b1);
    wr(8'hA3, 1'b1, 1'b0, 1'b1);
    wr(8'hA4, 1'b1, 1'b0, 1'b1);
    wr(8'hA5, 1'b1, 1'b0, 1'b1);
    check("t5_count_full", bus.count, 4);
    repeat (36) @(negedge clock);
    check("t5_busy_before_pop", bus.busy, 1);
    wr(8'hA6, 1'b0, 1'b1, 1'b1);
    check("t5_count_same", bus.count, 4);
    check("t5_full_same", bus.full, 1);
    check("t5_overflow_clear", bus.overflow, 0);
    drain("t5");
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_overflow_end", bus.overflow, 0);

    // Reset mid-frame during data bit 3
    wr(8'hF0, 1'b1, 1'b0, 1'b1);
    repeat (18) @(negedge clock);
    check("t6_line_bit3", bus.serial_out, 0);
    check("t6_busy_mid", bus.busy, 1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_line_async", bus.serial_out, 1);
    check("t6_busy_async", bus.busy, 0);
    check("t6_count_async", bus.count, 0);
    check("t6_overflow_async", bus.overflow, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    wr(8'h96, 1'b1, 1'b0, 1'b1);
    drain("t6");
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_empty_end", bus.empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_out_buffer.md
Name: serial_out_buffer

Overview:
- Downstream stage of the two-requester arbiter; consumes the granted 8-bit word and shifts it out on a single serial line.
- Any grant writes the byte into a small FIFO. A framed transmitter drains the FIFO: start bit, 8 data bits LSB-first, stop bit, each bit CLKS_PER_BIT clocks long.
- full and empty are returned to the requesters so they stop requesting while no FIFO slot is free.

Parameters:
DATA_W, 8, width of each buffered word and of the data field of a frame
DEPTH, 4, FIFO entries; power of two, minimum 2
CLKS_PER_BIT, 4, clock cycles per serial bit; minimum 1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears FIFO, FSM and all outputs
data  in  DATA_W  word presented alongside the grants
gnt_0  in  1  grant to requester 0; write strobe
gnt_1  in  1  grant to requester 1; write strobe
serial_out  out  1  framed serial line; idles high
busy  out  1  high while a frame is on the line (START/DATA/STOP)
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  $clog2(DEPTH+1)  current FIFO occupancy
overflow  out  1  sticky; set when a write is dropped

Behaviour:
- Reset values: serial_out=1, busy=0, full=0, empty=1, count=0, overflow=0; FSM=IDLE. Reset asserted mid-frame aborts the frame; the line returns high immediately (asynchronously).
- Write:
  - wr = gnt_0 | gnt_1, sampled on the rising edge.
  - Both grants high together is a single write, not two.
  - The write is accepted if count<DEPTH, or if count==DEPTH and a pop occurs on the same edge.
  - Otherwise the word is dropped and overflow is set. overflow clears only on reset.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - count = count + wr_accepted − pop.
  - Simultaneous write and pop leaves count unchanged.
  - A write into an empty FIFO cannot be popped on the same edge; the first-word latency is fixed as below.
- FSM states:
  - IDLE: serial_out=1, busy=0. If count>0, pop the head word into the shift register, clear bit_cnt/tick_cnt, and go to START.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: serial_out=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment bit_cnt. After DATA_W bits, go to STOP.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles. At the final tick, if count>0, pop and go directly to START (no idle gap); else go to IDLE.
- Timing:
  - Word written at edge E0 (empty FIFO, IDLE): the pop is at edge E1, and serial_out falls after E1.
  - A frame occupies exactly (DATA_W+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames are contiguous.
- Counters:
  - tick_cnt is $clog2(CLKS_PER_BIT) bits wide, minimum 1; it counts 0..CLKS_PER_BIT-1.
  - bit_cnt is $clog2(DATA_W+1) bits wide.
- All outputs are registered except full, empty and busy, which are decoded from registered count and state.

Decomposition:
- Shared package serial_out_pkg holds:
  - state enum (IDLE, START, DATA, STOP)
  - idle line level constant LINE_IDLE=1
  - start bit constant START_BIT=0
- One sub-module: sync_fifo (DATA_W, DEPTH; push, pop, dout, full, empty, count).
- The top module holds the FSM, tick/bit counters and shift register.

Test Plan:
1. Reset, then one write data=8'hA5 via gnt_0 -> serial_out falls 1 cycle after the capture edge, then 4 cycles each of 0,1,0,1,0,0,1,0,1,1; busy high 40 cycles; empty=1 afterwards.
2. Four writes 8'h01,8'h02,8'h03,8'h04 on consecutive cycles -> count reaches 3 (first word already popped); frames are sent in order with no idle gap; busy high continuously for 160 cycles.
3. Five writes during the first frame's START, then a 6th write -> full=1 at count=4; the 6th word is dropped; overflow=1 and stays set; the dropped word is never transmitted.
4. gnt_0 and gnt_1 both high for one cycle with data=8'h3C -> exactly one entry (count=1 before the pop); exactly one frame carrying 8'h3C.
5. Full FIFO with a write coinciding with the STOP-end pop -> write accepted; count stays 4; overflow stays 0.
6. Assert reset during DATA bit 3 -> serial_out=1 immediately; count=0, busy=0, overflow=0; a new write afterwards transmits a clean frame.
